// File: rtl/button_repeat.sv
// Turns one debounced button level into press / auto-repeat / release strobes for time setting.
// Optional build macro BUTTON_REPEAT_ACCEL_EN switches to a faster repeat rate after ACCEL_AFTER repeats.
module button_repeat #(
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10,
  parameter int unsigned ACCEL_AFTER  = 8,
  parameter int unsigned FAST_TICKS   = 3
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_tick_stb,
  input  logic i_button_state,
  output logic o_press_stb,
  output logic o_repeat_stb,
  output logic o_event_stb,
  output logic o_release_stb,
  output logic o_long_press
);

  localparam int unsigned MAX_HR    = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_HR > FAST_TICKS) ? MAX_HR : FAST_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

  if (HOLD_TICKS < 1 || REPEAT_TICKS < 1 || ACCEL_AFTER < 1 || FAST_TICKS < 1) begin : g_bad_cfg
    $error("button_repeat: all tick/count parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_last_c;
  logic             prev_q;
  logic             press_c, repeat_c, release_c;

`ifdef BUTTON_REPEAT_ACCEL_EN
  localparam int unsigned REP_W = $clog2(ACCEL_AFTER + 1);
  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_sat_c;

  // Period drops to FAST_TICKS once the saturating repeat count reaches ACCEL_AFTER.
  assign rep_sat_c     = (rep_q == REP_W'(ACCEL_AFTER));
  assign period_last_c = rep_sat_c ? CNT_W'(FAST_TICKS - 1) : CNT_W'(REPEAT_TICKS - 1);
`else
  assign period_last_c = CNT_W'(REPEAT_TICKS - 1);
`endif

  // Next-state and strobe decode; release takes priority over a coincident terminal tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_c   = 1'b0;
    repeat_c  = 1'b0;
    release_c = 1'b0;
`ifdef BUTTON_REPEAT_ACCEL_EN
    rep_d     = rep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_button_state && !prev_q) begin
          state_d = ST_HOLD;
          press_c = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (!i_button_state) begin
          state_d   = ST_IDLE;
          release_c = 1'b1;
          cnt_d     = '0;
        end else if (i_tick_stb) begin
          if (cnt_q == CNT_W'(HOLD_TICKS - 1)) begin
            state_d  = ST_REPEAT;
            repeat_c = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_REPEAT: begin
        if (!i_button_state) begin
          state_d   = ST_IDLE;
          release_c = 1'b1;
          cnt_d     = '0;
`ifdef BUTTON_REPEAT_ACCEL_EN
          rep_d     = '0;
`endif
        end else if (i_tick_stb) begin
          if (cnt_q == period_last_c) begin
            repeat_c = 1'b1;
            cnt_d    = '0;
`ifdef BUTTON_REPEAT_ACCEL_EN
            if (!rep_sat_c) rep_d = rep_q + REP_W'(1);
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; i_en low freezes state and suppresses strobes.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      prev_q        <= 1'b0;
      o_press_stb   <= 1'b0;
      o_repeat_stb  <= 1'b0;
      o_event_stb   <= 1'b0;
      o_release_stb <= 1'b0;
      o_long_press  <= 1'b0;
`ifdef BUTTON_REPEAT_ACCEL_EN
      rep_q         <= '0;
`endif
    end else if (i_en) begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_q        <= i_button_state;
      o_press_stb   <= press_c;
      o_repeat_stb  <= repeat_c;
      o_event_stb   <= press_c | repeat_c;
      o_release_stb <= release_c;
      o_long_press  <= (state_d == ST_REPEAT);
`ifdef BUTTON_REPEAT_ACCEL_EN
      rep_q         <= rep_d;
`endif
    end else begin
      o_press_stb   <= 1'b0;
      o_repeat_stb  <= 1'b0;
      o_event_stb   <= 1'b0;
      o_release_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_repeat.sv
// Directed bench for button_repeat: HOLD=4, REPEAT=2, ACCEL_AFTER=2, FAST=1, tick every 4 clocks.
module tb_button_repeat;

  logic clk = 1'b0;
  logic reset_n, en, tick_stb, button;
  logic press_stb, repeat_stb, event_stb, release_stb, long_press;

  int errors = 0;
  int checks = 0;

  // Tallies gathered while stepping, cleared per scenario.
  int          n_press, n_rep, n_rel, n_evt_bad, tick_cnt, long_tick;
  logic        long_seen;
  logic [31:0] rep_mask;

  button_repeat #(
    .HOLD_TICKS  (4),
    .REPEAT_TICKS(2),
    .ACCEL_AFTER (2),
    .FAST_TICKS  (1)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_en          (en),
    .i_tick_stb    (tick_stb),
    .i_button_state(button),
    .o_press_stb   (press_stb),
    .o_repeat_stb  (repeat_stb),
    .o_event_stb   (event_stb),
    .o_release_stb (release_stb),
    .o_long_press  (long_press)
  );

  always #5 clk = ~clk;

  task automatic clear_tally();
    n_press   = 0;
    n_rep     = 0;
    n_rel     = 0;
    tick_cnt  = 0;
    long_tick = -1;
    long_seen = 1'b0;
    rep_mask  = '0;
  endtask

  // Drive one clock at the negedge, sample the result at the following negedge.
  task automatic step(input logic btn, input logic tick, input logic enable);
    button   = btn;
    tick_stb = tick;
    en       = enable;
    @(negedge clk);
    if (tick && enable && reset_n) tick_cnt++;
    if (press_stb === 1'b1) n_press++;
    if (release_stb === 1'b1) n_rel++;
    if (repeat_stb === 1'b1) begin
      n_rep++;
      if (tick_cnt < 32) rep_mask[tick_cnt] = 1'b1;
    end
    if (long_press === 1'b1 && !long_seen) begin
      long_seen = 1'b1;
      long_tick = tick_cnt;
    end
    if (event_stb !== (press_stb | repeat_stb) || (press_stb === 1'b1 && repeat_stb === 1'b1))
      n_evt_bad++;
  endtask

  task automatic tick4(input logic btn, input logic enable);
    step(btn, 1'b0, enable);
    step(btn, 1'b0, enable);
    step(btn, 1'b0, enable);
    step(btn, 1'b1, enable);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b1);
    checks++;
    if ({press_stb, repeat_stb, event_stb, release_stb, long_press} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000",
               {press_stb, repeat_stb, event_stb, release_stb, long_press});
    end
    reset_n = 1'b1;
    clear_tally();
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (press_stb !== 1'b1 || event_stb !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_press: press=%b event=%b want 1 1", press_stb, event_stb);
    end
    repeat (5) step(1'b1, 1'b0, 1'b1);
    checks++;
    if (n_press !== 1) begin
      errors++;
      $display("FAIL reset_press_once: got %0d presses want 1", n_press);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (release_stb !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got %b want 1", release_stb);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (release_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_pulse: got %b want 0", release_stb);
    end
  endtask

  task automatic test_short_hold();
    clear_tally();
    step(1'b1, 1'b0, 1'b1);
    repeat (3) tick4(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (n_press !== 1 || n_rep !== 0 || n_rel !== 1) begin
      errors++;
      $display("FAIL short_hold_counts: press=%0d rep=%0d rel=%0d want 1 0 1", n_press, n_rep, n_rel);
    end
    checks++;
    if (long_seen !== 1'b0) begin
      errors++;
      $display("FAIL short_hold_long: got %b want 0", long_seen);
    end
  endtask

  task automatic test_repeat();
    logic [31:0] exp_mask;
    int          exp_n;
`ifdef BUTTON_REPEAT_ACCEL_EN
    exp_mask = 32'h0000_0750;
    exp_n    = 5;
`else
    exp_mask = 32'h0000_0550;
    exp_n    = 4;
`endif
    clear_tally();
    step(1'b1, 1'b0, 1'b1);
    repeat (10) tick4(1'b1, 1'b1);
    checks++;
    if (rep_mask !== exp_mask || n_rep !== exp_n) begin
      errors++;
      $display("FAIL repeat_ticks: mask=%h n=%0d want mask=%h n=%0d", rep_mask, n_rep, exp_mask, exp_n);
    end
    checks++;
    if (long_tick !== 4) begin
      errors++;
      $display("FAIL repeat_long_start: got tick %0d want 4", long_tick);
    end
    checks++;
    if (long_press !== 1'b1) begin
      errors++;
      $display("FAIL repeat_long_level: got %b want 1", long_press);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (release_stb !== 1'b1 || long_press !== 1'b0) begin
      errors++;
      $display("FAIL repeat_release: rel=%b long=%b want 1 0", release_stb, long_press);
    end
  endtask

  task automatic test_release_on_tick();
    clear_tally();
    step(1'b1, 1'b0, 1'b1);
    repeat (3) tick4(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (release_stb !== 1'b1 || repeat_stb !== 1'b0 || n_rep !== 0) begin
      errors++;
      $display("FAIL release_on_tick: rel=%b rep=%b nrep=%0d want 1 0 0", release_stb, repeat_stb, n_rep);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (long_press !== 1'b0 || repeat_stb !== 1'b0) begin
      errors++;
      $display("FAIL release_on_tick_idle: long=%b rep=%b want 0 0", long_press, repeat_stb);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (press_stb !== 1'b1) begin
      errors++;
      $display("FAIL release_on_tick_repress: got %b want 1", press_stb);
    end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_enable_mask();
    int strobes_masked;
    clear_tally();
    step(1'b1, 1'b0, 1'b1);
    tick4(1'b1, 1'b1);
    tick4(1'b1, 1'b1);
    strobes_masked = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, ((i % 4) == 3) ? 1'b1 : 1'b0, 1'b0);
      if (press_stb | repeat_stb | event_stb | release_stb) strobes_masked++;
    end
    checks++;
    if (strobes_masked !== 0 || n_rep !== 0) begin
      errors++;
      $display("FAIL enable_mask_quiet: strobe cycles=%0d rep=%0d want 0 0", strobes_masked, n_rep);
    end
    tick4(1'b1, 1'b1);
    checks++;
    if (n_rep !== 0) begin
      errors++;
      $display("FAIL enable_mask_early: got %0d repeats at tick 3 want 0", n_rep);
    end
    tick4(1'b1, 1'b1);
    checks++;
    if (rep_mask !== 32'h0000_0010 || n_rep !== 1) begin
      errors++;
      $display("FAIL enable_mask_resume: mask=%h n=%0d want mask=00000010 n=1", rep_mask, n_rep);
    end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_repeat();
    clear_tally();
    step(1'b1, 1'b0, 1'b1);
    repeat (5) tick4(1'b1, 1'b1);
    checks++;
    if (long_press !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_repeat: long=%b want 1", long_press);
    end
    clear_tally();
    reset_n = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if ({press_stb, repeat_stb, event_stb, release_stb, long_press} !== 5'b0 || n_rel !== 0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b rel=%0d want 00000 0",
               {press_stb, repeat_stb, event_stb, release_stb, long_press}, n_rel);
    end
    reset_n = 1'b1;
    clear_tally();
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (press_stb !== 1'b1) begin
      errors++;
      $display("FAIL midreset_press: got %b want 1", press_stb);
    end
    repeat (4) tick4(1'b1, 1'b1);
    checks++;
    if (rep_mask !== 32'h0000_0010 || n_rep !== 1 || long_tick !== 4 || n_rel !== 0) begin
      errors++;
      $display("FAIL midreset_hold: mask=%h n=%0d long_tick=%0d rel=%0d want 00000010 1 4 0",
               rep_mask, n_rep, long_tick, n_rel);
    end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_event_consistency();
    checks++;
    if (n_evt_bad !== 0) begin
      errors++;
      $display("FAIL event_or: %0d cycles with bad o_event_stb or press+repeat overlap, want 0", n_evt_bad);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    en        = 1'b1;
    tick_stb  = 1'b0;
    button    = 1'b1;
    n_evt_bad = 0;
    clear_tally();
    @(negedge clk);
    test_reset();
    test_short_hold();
    test_repeat();
    test_release_on_tick();
    test_enable_mask();
    test_reset_mid_repeat();
    test_event_consistency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
